// File: rtl/axi_rd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_ctrl_pkg
// Description : Shared AXI4-lite read-path widths, response codes and states.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_rd_ctrl_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int NUM_MASTERS = 3;
    localparam int NUM_SLAVES  = 6;
    localparam int REGION_W    = 4;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ARVLD = 2'd1,
        RD_RVLD  = 2'd2,
        RD_ERR   = 2'd3
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rr_arbiter
// Description : 3-way round-robin pick with a registered last-served pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rr_arbiter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] req_i,
    input  logic       upd_i,
    input  logic [1:0] upd_idx_i,
    output logic [2:0] grant_o,
    output logic [1:0] grant_idx_o
);

    logic [1:0] last_q;
    logic [1:0] last_d;
    logic [1:0] cand;
    logic       found;

    // Search begins one past the last master that completed.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 0; k < 3; k++) begin
            cand = 2'((int'(last_q) + 1 + k) % 3);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_idx_o   = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (upd_i) begin
            last_d = upd_idx_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 2'd2;
        end else begin
            last_q <= last_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_ctrl
// Description : AXI4-lite read controller: 3 masters, 6 slaves, local DECERR.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_ctrl #(
    parameter int AXI_ADDR_WIDTH = axi_rd_ctrl_pkg::AXI_ADDR_WIDTH,
    parameter int AXI_DATA_WIDTH = axi_rd_ctrl_pkg::AXI_DATA_WIDTH
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [2:0]                  m_arvalid,
    output logic [2:0]                  m_arready,
    input  logic [3*AXI_ADDR_WIDTH-1:0] m_araddr,
    input  logic [8:0]                  m_arprot,
    output logic [2:0]                  m_rvalid,
    input  logic [2:0]                  m_rready,
    output logic [3*AXI_DATA_WIDTH-1:0] m_rdata,
    output logic [5:0]                  m_rresp,
    output logic [5:0]                  s_arvalid,
    input  logic [5:0]                  s_arready,
    output logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
    output logic [2:0]                  s_arprot,
    input  logic [5:0]                  s_rvalid,
    output logic [5:0]                  s_rready,
    input  logic [6*AXI_DATA_WIDTH-1:0] s_rdata,
    input  logic [11:0]                 s_rresp,
    output logic [2:0]                  rd_grant,
    output logic                        rd_busy
);
    import axi_rd_ctrl_pkg::*;

    rd_state_e                 state_q, state_d;
    logic [1:0]                gidx_q, gidx_d;
    logic [2:0]                sel_q, sel_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]                prot_q, prot_d;
    logic                      errrsp_q, errrsp_d;

    logic [2:0]                arb_grant;
    logic [1:0]                arb_idx;
    logic                      arb_upd;
    logic [AXI_ADDR_WIDTH-1:0] req_addr;
    logic [REGION_W-1:0]       req_region;

    axi_rr_arbiter u_arb (
        .clk_i       (ACLK),
        .rst_i       (ARESET),
        .req_i       (m_arvalid),
        .upd_i       (arb_upd),
        .upd_idx_i   (gidx_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx)
    );

    assign req_addr   = m_araddr[int'(arb_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    assign req_region = req_addr[AXI_ADDR_WIDTH-1 -: REGION_W];
    assign rd_busy    = (state_q != RD_IDLE);

    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        prot_d    = prot_q;
        errrsp_d  = errrsp_q;
        arb_upd   = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        s_arvalid = '0;
        s_rready  = '0;
        rd_grant  = '0;
        s_araddr  = addr_q;
        s_arprot  = prot_q;

        if (state_q != RD_IDLE) begin
            rd_grant[gidx_q] = 1'b1;
        end

        case (state_q)
            RD_IDLE: begin
                if (|arb_grant) begin
                    gidx_d   = arb_idx;
                    sel_d    = req_region[2:0];
                    addr_d   = req_addr;
                    prot_d   = m_arprot[int'(arb_idx)*3 +: 3];
                    errrsp_d = 1'b0;
                    state_d  = (int'(req_region) < NUM_SLAVES) ? RD_ARVLD : RD_ERR;
                end
            end
            RD_ARVLD: begin
                s_arvalid[sel_q]  = 1'b1;
                m_arready[gidx_q] = s_arready[sel_q];
                if (s_arready[sel_q]) begin
                    state_d = RD_RVLD;
                end
            end
            RD_RVLD: begin
                m_rvalid[gidx_q] = s_rvalid[sel_q];
                m_rdata[int'(gidx_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] =
                    s_rdata[int'(sel_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                m_rresp[int'(gidx_q)*2 +: 2] = s_rresp[int'(sel_q)*2 +: 2];
                s_rready[sel_q] = m_rready[gidx_q];
                if (s_rvalid[sel_q] && m_rready[gidx_q]) begin
                    arb_upd = 1'b1;
                    state_d = RD_IDLE;
                end
            end
            RD_ERR: begin
                // First ERR cycle accepts the address; the response follows.
                if (!errrsp_q) begin
                    m_arready[gidx_q] = 1'b1;
                    errrsp_d          = 1'b1;
                end else begin
                    m_rvalid[gidx_q]             = 1'b1;
                    m_rresp[int'(gidx_q)*2 +: 2] = RESP_DECERR;
                    if (m_rready[gidx_q]) begin
                        arb_upd = 1'b1;
                        state_d = RD_IDLE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= RD_IDLE;
            gidx_q   <= '0;
            sel_q    <= '0;
            addr_q   <= '0;
            prot_q   <= '0;
            errrsp_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gidx_q   <= gidx_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            prot_q   <= prot_d;
            errrsp_q <= errrsp_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_ctrl
// Description : Self-checking bench for axi_rd_ctrl with a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [2:0]    m_arvalid, m_arready, m_rvalid, m_rready, rd_grant;
    logic [3*AW-1:0] m_araddr;
    logic [8:0]    m_arprot;
    logic [3*DW-1:0] m_rdata;
    logic [5:0]    m_rresp, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [AW-1:0] s_araddr;
    logic [2:0]    s_arprot;
    logic [6*DW-1:0] s_rdata;
    logic [11:0]   s_rresp;
    logic          rd_busy;

    logic [AW-1:0] maddr [3];
    logic [2:0]    mprot [3];

    int n_assert = 0;
    int n_fail   = 0;
    int model_last = 2;

    assign m_araddr = {maddr[2], maddr[1], maddr[0]};
    assign m_arprot = {mprot[2], mprot[1], mprot[0]};

    always #5 ACLK = ~ACLK;

    axi_rd_ctrl dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arprot(m_arprot), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arprot(s_arprot), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rresp(s_rresp),
        .rd_grant(rd_grant), .rd_busy(rd_busy)
    );

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Round-robin rule: first requester at last+1, last+2, last+3 (mod 3).
    function automatic int pick(input logic [2:0] req);
        for (int k = 1; k <= 3; k++) begin
            if (req[(model_last + k) % 3]) return (model_last + k) % 3;
        end
        return -1;
    endfunction

    task automatic all_quiet(input string tag);
        chk({tag, "_grant"}, rd_grant, 0);
        chk({tag, "_busy"}, rd_busy, 0);
        chk({tag, "_sarvalid"}, s_arvalid, 0);
        chk({tag, "_marready"}, m_arready, 0);
        chk({tag, "_mrvalid"}, m_rvalid, 0);
        chk({tag, "_srready"}, s_rready, 0);
        chk({tag, "_mrdata"}, m_rdata, 0);
        chk({tag, "_saraddr"}, s_araddr, 0);
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        tick();
        tick();
        ARESET = 1'b0;
        model_last = 2;
    endtask

    // One full read for the model-chosen master; DUT must be idle on entry.
    task automatic serve(input int arw, input int rw, input int mrw, input logic [2:0] late,
                         input logic [DW-1:0] data, input logic [1:0] resp);
        int g, sel;
        logic [AW-1:0] a;
        g = pick(m_arvalid);
        if (g < 0) return;
        a   = maddr[g];
        sel = int'(a[AW-1 -: 4]);
        chk("idle_busy", rd_busy, 0);
        chk("idle_sarvalid", s_arvalid, 0);
        tick();
        chk("grant", rd_grant, 3'b001 << g);
        chk("busy", rd_busy, 1);
        if (sel < 6) begin
            for (int i = 0; i <= arw; i++) begin
                chk("s_arvalid", s_arvalid, 6'b000001 << sel);
                chk("s_araddr", s_araddr, a);
                chk("s_arprot", s_arprot, mprot[g]);
                chk("ar_grant", rd_grant, 3'b001 << g);
                if (i < arw) begin
                    chk("arready_wait", m_arready, 0);
                    tick();
                end
            end
            s_arready[sel] = 1'b1;
            #1;
            chk("arready_pulse", m_arready, 3'b001 << g);
            tick();
            s_arready = '0;
            m_arvalid[g] = 1'b0;
            m_arvalid = m_arvalid | late;
            chk("r_sarvalid", s_arvalid, 0);
            chk("r_arready", m_arready, 0);
            repeat (rw) begin
                chk("rvalid_wait", m_rvalid, 0);
                tick();
            end
            s_rvalid[sel] = 1'b1;
            s_rdata[sel*DW +: DW] = data;
            s_rresp[sel*2 +: 2] = resp;
            #1;
            for (int i = 0; i <= mrw; i++) begin
                chk("m_rvalid", m_rvalid, 3'b001 << g);
                chk("m_rdata", m_rdata, 192'(data) << (g * DW));
                chk("m_rresp", m_rresp, 6'(resp) << (g * 2));
                chk("r_grant", rd_grant, 3'b001 << g);
                chk("r_saraddr", s_araddr, a);
                if (i < mrw) begin
                    chk("srready_wait", s_rready, 0);
                    tick();
                end
            end
            m_rready[g] = 1'b1;
            #1;
            chk("s_rready", s_rready, 6'b000001 << sel);
            tick();
            s_rvalid = '0;
            s_rdata  = '0;
            s_rresp  = '0;
            m_rready = '0;
        end else begin
            chk("err_sarvalid", s_arvalid, 0);
            chk("err_arready", m_arready, 3'b001 << g);
            chk("err_rvalid0", m_rvalid, 0);
            tick();
            m_arvalid[g] = 1'b0;
            m_arvalid = m_arvalid | late;
            for (int i = 0; i <= mrw; i++) begin
                chk("err_rvalid", m_rvalid, 3'b001 << g);
                chk("err_rresp", m_rresp, 6'b000011 << (g * 2));
                chk("err_rdata", m_rdata, 0);
                chk("err_arready_once", m_arready, 0);
                chk("err_slave_quiet", {s_arvalid, s_rready}, 0);
                if (i < mrw) tick();
            end
            m_rready[g] = 1'b1;
            tick();
            m_rready = '0;
        end
        model_last = g;
        chk("gap_busy", rd_busy, 0);
        chk("gap_grant", rd_grant, 0);
    endtask

    initial begin
        m_arvalid = '0; m_rready = '0; s_arready = '0; s_rvalid = '0;
        s_rdata = '0; s_rresp = '0;
        for (int i = 0; i < 3; i++) begin
            maddr[i] = '0;
            mprot[i] = 3'(i + 1);
        end
        do_reset();
        all_quiet("reset");

        // Single M0 read to S1
        maddr[0] = 32'h1000_0040;
        m_arvalid = 3'b001;
        serve(0, 0, 0, 3'b000, 32'hDEAD_BEEF, 2'b00);

        // All three request from reset: M0, M1, M2, M0
        do_reset();
        maddr[0] = 32'h2000_0100; maddr[1] = 32'h4000_0200; maddr[2] = 32'h5000_0300;
        for (int r = 0; r < 4; r++) begin
            m_arvalid = 3'b111;
            chk("rr_order", pick(m_arvalid), r % 3);
            serve(0, 0, 0, 3'b000, $urandom, 2'b00);
        end
        m_arvalid = '0;

        // Unmapped read from M2 with master backpressure
        maddr[2] = 32'h7000_0000;
        m_arvalid = 3'b100;
        serve(0, 0, 4, 3'b000, '0, 2'b00);

        // Slave AR stall of 5 and master R stall of 3 on S3
        maddr[1] = 32'h3000_1234;
        m_arvalid = 3'b010;
        serve(5, 0, 3, 3'b000, 32'hCAFE_F00D, 2'b10);

        // M0 requests while M1 is mid-read; M0 wins next
        maddr[1] = 32'h0000_0008;
        maddr[0] = 32'h1000_0010;
        m_arvalid = 3'b010;
        serve(0, 1, 1, 3'b001, 32'h1234_5678, 2'b00);
        chk("late_winner", pick(m_arvalid), 0);
        serve(0, 0, 0, 3'b000, 32'h8765_4321, 2'b00);

        // Reset while the slave is presenting R data
        maddr[1] = 32'h2000_0000;
        m_arvalid = 3'b010;
        tick();
        s_arready[2] = 1'b1;
        tick();
        s_arready = '0;
        m_arvalid = '0;
        s_rvalid[2] = 1'b1;
        s_rdata[2*DW +: DW] = 32'hFFFF_0000;
        #1;
        chk("pre_reset_rvalid", m_rvalid, 3'b010);
        ARESET = 1'b1;
        #1;
        all_quiet("async_reset");
        tick();
        ARESET = 1'b0;
        model_last = 2;
        tick();
        all_quiet("late_rvalid");
        s_rvalid = '0;
        s_rdata  = '0;
        maddr[0] = 32'h0000_0004; maddr[1] = 32'h1000_0004; maddr[2] = 32'h2000_0004;
        m_arvalid = 3'b111;
        chk("post_reset_pick", pick(m_arvalid), 0);
        serve(0, 0, 0, 3'b000, 32'h0BAD_F00D, 2'b00);

        // Randomized traffic with held requests
        for (int it = 0; it < 40; it++) begin
            for (int m = 0; m < 3; m++) begin
                if (!m_arvalid[m] && $urandom_range(0, 1) == 1) begin
                    maddr[m] = {4'($urandom_range(0, 15)), 28'($urandom)};
                    mprot[m] = 3'($urandom);
                    m_arvalid[m] = 1'b1;
                end
            end
            if (m_arvalid == 3'b000) begin
                maddr[0] = {4'($urandom_range(0, 15)), 28'($urandom)};
                m_arvalid[0] = 1'b1;
            end
            serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 3'b000,
                  $urandom, 2'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
